// File: rtl/pipe_chain.sv
// pipe_chain: a chain of DEPTH bubble-collapsing valid/ready register stages carrying a
// DATA_W payload, with an optional one-entry input skid buffer (SKID=1) so that pin_ready
// is a flop output. Provides a synchronous flush and an occupancy count.
//
// Ports:
//   clk, rst      clock (posedge) and synchronous active-high reset
//   flush         drop every held beat at the next edge
//   pin_valid     upstream beat valid
//   pin_ready     beat accepted this cycle
//   pin_data      upstream payload
//   pout_valid    output beat valid (flop output)
//   pout_ready    downstream accepts
//   pout_data     output payload (last stage register)
//   count         beats currently held, 0..DEPTH+SKID
module pipe_chain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned SKID   = 0,
  parameter int unsigned CNT_W  = $clog2(DEPTH + SKID + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              pin_valid,
  output logic              pin_ready,
  input  logic [DATA_W-1:0] pin_data,
  output logic              pout_valid,
  input  logic              pout_ready,
  output logic [DATA_W-1:0] pout_data,
  output logic [CNT_W-1:0]  count
);

  logic [DEPTH-1:0]  v_q, v_d;
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [DATA_W-1:0] d_d [DEPTH];
  logic              sv_q, sv_d;
  logic [DATA_W-1:0] sd_q, sd_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DEPTH:0]    rdy;
  logic [DEPTH-1:0]  vin;
  logic [DATA_W-1:0] din [DEPTH];
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              in_xfer, out_xfer;

  assign pout_valid = v_q[DEPTH-1];
  assign pout_data  = d_q[DEPTH-1];
  assign count      = count_q;

  // Readiness ripples back from the output; an empty stage always accepts.
  always_comb begin
    rdy = '0;
    rdy[DEPTH] = pout_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      rdy[i] = ~v_q[i] | rdy[i+1];
    end
  end

  // Stage 0 source: the skid entry when occupied, otherwise the input port directly, so an
  // empty skid adds no latency.
  always_comb begin
    if (SKID != 0) begin
      pin_ready = ~sv_q;
      src_valid = sv_q | pin_valid;
      src_data  = sv_q ? sd_q : pin_data;
    end else begin
      pin_ready = rdy[0];
      src_valid = pin_valid;
      src_data  = pin_data;
    end
  end

  assign in_xfer  = pin_valid & pin_ready;
  assign out_xfer = pout_valid & pout_ready;

  always_comb begin
    vin    = '0;
    vin[0] = src_valid;
    din[0] = src_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      vin[i] = v_q[i-1];
      din[i] = d_q[i-1];
    end
  end

  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    sv_d    = sv_q;
    sd_d    = sd_q;
    count_d = count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (rdy[i]) begin
        v_d[i] = vin[i];
        // Payload only moves with a valid beat; bubbles leave the data register untouched.
        if (vin[i]) d_d[i] = din[i];
      end
    end

    if (SKID != 0) begin
      // Capture needs sv_q=0 and drain needs sv_q=1, so the two never coincide.
      if (pin_valid && pin_ready && !rdy[0]) begin
        sv_d = 1'b1;
        sd_d = pin_data;
      end else if (sv_q && rdy[0]) begin
        sv_d = 1'b0;
      end
    end

    // Flush wins over every load; payload registers keep their old contents.
    if (flush) begin
      v_d     = '0;
      d_d     = d_q;
      sv_d    = 1'b0;
      sd_d    = sd_q;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d_q[i] <= '0;
      end
      sv_q    <= 1'b0;
      sd_q    <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      sv_q    <= sv_d;
      sd_q    <= sd_d;
      count_q <= count_d;
    end
  end

endmodule
